// File: rtl/native_bus_interconnect_pkg.sv
// Shared types and constants for the picorv32 native-bus interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

endpackage

// File: rtl/native_bus_interconnect_if.sv
// Core-side and slave-side native bus signals of the interconnect.
interface native_bus_interconnect_if #(
  parameter int N_SLAVES = 4
);
  logic                     m_valid;
  logic                     m_instr;
  logic [31:0]              m_addr;
  logic [31:0]              m_wdata;
  logic [3:0]               m_wstrb;
  logic                     m_ready;
  logic [31:0]              m_rdata;

  logic [N_SLAVES-1:0]      s_valid;
  logic                     s_instr;
  logic [31:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [3:0]               s_wstrb;
  logic [N_SLAVES-1:0]      s_ready;
  logic [N_SLAVES*32-1:0]   s_rdata;

  logic                     bus_err;
  logic [31:0]              err_addr;

  modport master (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata, bus_err, err_addr
  );

  modport slave (
    input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

  modport ic (
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb,
           bus_err, err_addr
  );
endinterface

// File: rtl/native_bus_interconnect_addr_decode.sv
// Priority address matcher: the lowest-index slave whose (addr & mask) == base wins.
module bus_addr_decode #(
  parameter int                      N_SLAVES   = 4,
  parameter int                      SEL_W      = 2,
  parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK = {N_SLAVES{32'h0}}
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  // Scan from the top so a lower index overwrites any higher match.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/native_bus_interconnect.sv
// Single-master, N-slave interconnect with registered request path,
// unmapped-address errors and slave timeouts.
module native_bus_interconnect
  import bus_pkg::*;
#(
  parameter int                      N_SLAVES   = 4,
  parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK = {N_SLAVES{32'h0}},
  parameter int                      TIMEOUT    = 255,
  parameter logic [31:0]             ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  native_bus_interconnect_if.ic bus
);

  // state  | meaning
  // IDLE   | wait for m_valid, decode address
  // ACCESS | s_valid to selected slave, count wait cycles
  // RESP   | response captured; m_ready issued on leaving
  // ERR    | unmapped address; error response issued on leaving
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state, state_d;
  bus_req_t            req, req_d;
  logic [SEL_W-1:0]    sel, sel_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                err_flag, err_flag_d;
  logic [31:0]         rdata, rdata_d;
  logic                m_ready_q, m_ready_d;
  logic                bus_err_q, bus_err_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [N_SLAVES-1:0] s_valid_q, s_valid_d;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic                sel_ready;
  logic [31:0]         sel_rdata;

  bus_addr_decode #(
    .N_SLAVES   (N_SLAVES),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr (bus.m_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign sel_ready = bus.s_ready[sel];
  assign sel_rdata = bus.s_rdata[32*sel +: 32];

  always_comb begin
    state_d    = state;
    req_d      = req;
    sel_d      = sel;
    cnt_d      = cnt;
    err_flag_d = err_flag;
    rdata_d    = rdata;
    m_ready_d  = 1'b0;
    bus_err_d  = 1'b0;
    err_addr_d = err_addr_q;
    s_valid_d  = '0;
    case (state)
      IDLE: begin
        if (bus.m_valid) begin
          if (dec_hit) begin
            req_d      = '{instr: bus.m_instr, addr: bus.m_addr,
                           wdata: bus.m_wdata, wstrb: bus.m_wstrb};
            sel_d      = dec_sel;
            cnt_d      = '0;
            err_flag_d = 1'b0;
            state_d    = ACCESS;
          end else begin
            err_addr_d = bus.m_addr;
            rdata_d    = ERR_DATA;
            state_d    = ERR;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          rdata_d    = ERR_DATA;
          err_flag_d = 1'b1;
          state_d    = RESP;
        end else if (cnt != '1) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        m_ready_d = 1'b1;
        if (err_flag) begin
          bus_err_d  = 1'b1;
          err_addr_d = req.addr;
        end
        state_d = IDLE;
      end
      ERR: begin
        m_ready_d = 1'b1;
        bus_err_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ACCESS) s_valid_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req        <= '0;
      sel        <= '0;
      cnt        <= '0;
      err_flag   <= 1'b0;
      rdata      <= '0;
      m_ready_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
      s_valid_q  <= '0;
    end else begin
      state      <= state_d;
      req        <= req_d;
      sel        <= sel_d;
      cnt        <= cnt_d;
      err_flag   <= err_flag_d;
      rdata      <= rdata_d;
      m_ready_q  <= m_ready_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
      s_valid_q  <= s_valid_d;
    end
  end

  assign bus.m_ready  = m_ready_q;
  assign bus.m_rdata  = rdata;
  assign bus.s_valid  = s_valid_q;
  assign bus.s_instr  = req.instr;
  assign bus.s_addr   = req.addr;
  assign bus.s_wdata  = req.wdata;
  assign bus.s_wstrb  = req.wstrb;
  assign bus.bus_err  = bus_err_q;
  assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_native_bus_interconnect.sv
// Randomized bench for native_bus_interconnect against a transaction-level model.
module tb_native_bus_interconnect;

  localparam int N   = 2;
  localparam int TMO = 8;
  localparam logic [63:0] BASE = {32'h1000_0000, 32'h0000_0000};
  localparam logic [63:0] MASK = {32'hFFFF_F000, 32'hFFFF_0000};
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  native_bus_interconnect_if #(.N_SLAVES(N)) bus ();

  native_bus_interconnect #(
    .N_SLAVES   (N),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK),
    .TIMEOUT    (TMO),
    .ERR_DATA   (ERRD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model_err_addr = 32'h0;
  logic [31:0] map_base [N] = '{32'h0000_0000, 32'h1000_0000};
  logic [31:0] map_mask [N] = '{32'hFFFF_0000, 32'hFFFF_F000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_target(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & map_mask[i]) == map_base[i]) return i;
    return -1;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "/m_ready"},  32'(bus.m_ready), 32'h0);
    check({tag, "/m_rdata"},  bus.m_rdata, 32'h0);
    check({tag, "/s_valid"},  32'(bus.s_valid), 32'h0);
    check({tag, "/s_addr"},   bus.s_addr, 32'h0);
    check({tag, "/s_wdata"},  bus.s_wdata, 32'h0);
    check({tag, "/s_wstrb"},  32'(bus.s_wstrb), 32'h0);
    check({tag, "/s_instr"},  32'(bus.s_instr), 32'h0);
    check({tag, "/bus_err"},  32'(bus.bus_err), 32'h0);
    check({tag, "/err_addr"}, bus.err_addr, 32'h0);
  endtask

  // Issues one request and plays the addressed slave, which raises ready
  // after 'waits' cycles of s_valid. Called right after a sampling point.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input int waits,
                         input logic [31:0] rd0, input logic [31:0] rd1, input bit spurious);
    int tgt;
    int exp_edge;
    logic [31:0] exp_rdata;
    logic exp_err;
    int vcnt;
    bit done;
    tgt = model_target(addr);
    vcnt = 0;
    done = 1'b0;
    if (tgt < 0) begin
      exp_edge = 1; exp_rdata = ERRD; exp_err = 1'b1;
    end else if (waits < TMO) begin
      exp_edge = waits + 2; exp_rdata = (tgt == 0) ? rd0 : rd1; exp_err = 1'b0;
    end else begin
      exp_edge = TMO + 1; exp_rdata = ERRD; exp_err = 1'b1;
    end
    if (exp_err) model_err_addr = addr;

    bus.m_valid = 1'b1;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_wstrb = wstrb;
    bus.m_instr = instr;
    bus.s_rdata = {rd1, rd0};
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      bus.s_ready = '0;
      if (tgt >= 0) begin
        if (bus.s_valid[tgt]) begin
          if (vcnt == waits) bus.s_ready[tgt] = 1'b1;
          vcnt++;
        end
        if (spurious) bus.s_ready[1 - tgt] = 1'b1;
      end
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        check({name, "/s_valid"}, 32'(bus.s_valid), (tgt >= 0) ? (32'h1 << tgt) : 32'h0);
        if (tgt >= 0) begin
          check({name, "/s_addr"},  bus.s_addr, addr);
          check({name, "/s_wdata"}, bus.s_wdata, wdata);
          check({name, "/s_wstrb"}, 32'(bus.s_wstrb), 32'(wstrb));
          check({name, "/s_instr"}, 32'(bus.s_instr), 32'(instr));
        end
      end
      if (bus.m_ready) begin
        done = 1'b1;
        check({name, "/latency"},  32'(cyc), 32'(exp_edge));
        check({name, "/m_rdata"},  bus.m_rdata, exp_rdata);
        check({name, "/bus_err"},  32'(bus.bus_err), 32'(exp_err));
        check({name, "/err_addr"}, bus.err_addr, model_err_addr);
        check({name, "/s_valid_end"}, 32'(bus.s_valid), 32'h0);
      end
    end
    if (!done) check({name, "/m_ready_bound"}, 32'(bus.m_ready), 32'h1);
    bus.m_valid = 1'b0;
    bus.s_ready = '0;
  endtask

  task automatic reset_mid_access();
    int seen;
    seen = 0;
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h0000_0040;
    bus.m_wstrb = 4'h0;
    bus.s_ready = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid/s_valid_before", 32'(bus.s_valid), 32'h1);
    reset = 1'b1;
    bus.m_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_err_addr = 32'h0;
    check_reset_values("rst_mid");
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.m_ready) seen++;
    end
    check("rst_mid/no_m_ready", 32'(seen), 32'h0);
  endtask

  initial begin
    int kind;
    int w;
    logic [31:0] a;
    logic [3:0] ws;
    bus.m_valid = 1'b0;
    bus.m_instr = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_ready = '0;
    bus.s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    run_txn("rd_s0", 32'h0000_0010, 32'h0, 4'h0, 1'b0, 0, 32'h1234_5678, $urandom, 1'b0);
    run_txn("wr_s1", 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 1'b0, 3, $urandom, 32'h0BAD_F00D, 1'b0);
    run_txn("unmapped", 32'h2000_0000, 32'h0, 4'h0, 1'b0, 0, $urandom, $urandom, 1'b0);
    run_txn("timeout", 32'h0000_0100, 32'h0, 4'h0, 1'b1, 100, $urandom, $urandom, 1'b0);
    run_txn("edge_ready", 32'h1000_0ffc, 32'h0, 4'h0, 1'b0, TMO - 1, $urandom, $urandom, 1'b0);
    run_txn("spurious", 32'h0000_0020, 32'h0, 4'h0, 1'b0, 2, $urandom, $urandom, 1'b1);
    reset_mid_access();

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {20'h10000, 12'($urandom)};
        default: a = $urandom;
      endcase
      w  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      run_txn($sformatf("rnd%0d", t), a, $urandom, ws, 1'($urandom), w,
              $urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
